// File: rtl/dac_spi_rx.sv
// DAC-side receiver for the cs/sclk/sdi/ldac serial link: oversampled, MSB-first, length-checked.
// Optional feature macro LDAC_LATCH_EN selects double-buffered (ldac-latched) output.
module dac_spi_rx #(
    parameter int DATA_W   = 16,
    parameter int SYNC_STG = 2,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              sclk,
    input  logic              sdi,
    input  logic              ldac,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    output logic              frm_err,
    output logic              busy,
    output logic [CNT_W-1:0]  frm_cnt
);

    localparam int BC_W    = $clog2(DATA_W + 2);
    localparam int ST_W    = $clog2(SYNC_STG + 2);
    localparam int CH_SDI  = 0;
    localparam int CH_CS   = 1;
    localparam int CH_SCLK = 2;
`ifdef LDAC_LATCH_EN
    localparam int NCH     = 4;
    localparam int CH_LDAC = 3;
`else
    localparam int NCH     = 3;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    logic [NCH-1:0]      pin_vec;
    logic [NCH-1:0]      sync_s;
    logic [SYNC_STG-1:0] sync_reg [NCH];
    logic [NCH-1:1]      dly_reg;

`ifdef LDAC_LATCH_EN
    assign pin_vec = {ldac, sclk, cs, sdi};
`else
    assign pin_vec = {sclk, cs, sdi};
    // ldac has no function in transparent mode
    logic ldac_unused;
    assign ldac_unused = ldac;
`endif

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_reg[gi] <= '1;
                end else begin
                    sync_reg[gi] <= {sync_reg[gi][SYNC_STG-2:0], pin_vec[gi]};
                end
            end
            assign sync_s[gi] = sync_reg[gi][SYNC_STG-1];
        end
        for (genvar gi = 1; gi < NCH; gi++) begin : g_dly
            always_ff @(posedge clk) begin
                if (rst) begin
                    dly_reg[gi] <= 1'b1;
                end else begin
                    dly_reg[gi] <= sync_s[gi];
                end
            end
        end
    endgenerate

    logic cs_rise, cs_fall, sclk_rise, sdi_sync;
    assign cs_rise   =  sync_s[CH_CS]   & ~dly_reg[CH_CS];
    assign cs_fall   = ~sync_s[CH_CS]   &  dly_reg[CH_CS];
    assign sclk_rise =  sync_s[CH_SCLK] & ~dly_reg[CH_SCLK];
    assign sdi_sync  =  sync_s[CH_SDI];
`ifdef LDAC_LATCH_EN
    logic ldac_fall;
    assign ldac_fall = ~sync_s[CH_LDAC] & dly_reg[CH_LDAC];
`endif

    // The preset synchroniser content is not a real cs-high observation, so arming
    // waits until the whole chain including the delay flop carries real samples.
    logic [ST_W-1:0] settle_reg;
    logic            settled;
    logic            armed_reg;
    assign settled = (settle_reg == ST_W'(SYNC_STG + 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            settle_reg <= '0;
            armed_reg  <= 1'b0;
        end else begin
            if (!settled) begin
                settle_reg <= settle_reg + 1'b1;
            end
            if (settled && sync_s[CH_CS] && dly_reg[CH_CS]) begin
                armed_reg <= 1'b1;
            end
        end
    end

    state_t              state_reg;
    logic [DATA_W-1:0]   shift_reg;
    logic [DATA_W-1:0]   shift_next;
    logic [DATA_W-1:0]   shadow_reg;
    logic [BC_W-1:0]     bit_cnt_reg;
    logic [BC_W-1:0]     bit_cnt_next;
    logic [DATA_W-1:0]   dout_reg;
    logic                dout_vld_reg;
    logic                frm_err_reg;
    logic                busy_reg;
    logic [CNT_W-1:0]    frm_cnt_reg;

    // Count saturates one past a full frame so overruns never alias to a good length.
    always_comb begin
        shift_next   = {shift_reg[DATA_W-2:0], sdi_sync};
        bit_cnt_next = bit_cnt_reg;
        if (bit_cnt_reg != BC_W'(DATA_W + 1)) begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            shadow_reg   <= '0;
            bit_cnt_reg  <= '0;
            dout_reg     <= '0;
            dout_vld_reg <= 1'b0;
            frm_err_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            frm_cnt_reg  <= '0;
        end else begin
            dout_vld_reg <= 1'b0;
            frm_err_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cs_fall && armed_reg) begin
                        bit_cnt_reg <= '0;
                        busy_reg    <= 1'b1;
                        state_reg   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        shift_reg   <= shift_next;
                        bit_cnt_reg <= bit_cnt_next;
                    end
                    if (cs_rise) begin
                        state_reg <= CHECK;
                    end
                end
                CHECK: begin
                    if (bit_cnt_reg == BC_W'(DATA_W)) begin
                        shadow_reg  <= shift_reg;
                        frm_cnt_reg <= frm_cnt_reg + 1'b1;
`ifndef LDAC_LATCH_EN
                        dout_reg     <= shift_reg;
                        dout_vld_reg <= 1'b1;
`endif
                    end else begin
                        frm_err_reg <= 1'b1;
                    end
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
`ifdef LDAC_LATCH_EN
            // Loads whatever shadow holds now, even mid-frame or with no new frame.
            if (ldac_fall) begin
                dout_reg     <= shadow_reg;
                dout_vld_reg <= 1'b1;
            end
`endif
        end
    end

    assign dout     = dout_reg;
    assign dout_vld = dout_vld_reg;
    assign frm_err  = frm_err_reg;
    assign busy     = busy_reg;
    assign frm_cnt  = frm_cnt_reg;

endmodule

// File: tb/tb_dac_spi_rx.sv
// Directed bench for dac_spi_rx; expectations depend on whether LDAC_LATCH_EN is defined.
module tb_dac_spi_rx;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cs = 1'b1;
    logic              sclk = 1'b0;
    logic              sdi = 1'b0;
    logic              ldac = 1'b1;
    logic [DATA_W-1:0] dout;
    logic              dout_vld;
    logic              frm_err;
    logic              busy;
    logic [CNT_W-1:0]  frm_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int vld_cnt  = 0;
    int err_cnt  = 0;
    int base_vld;
    int base_err;

    dac_spi_rx #(.DATA_W(DATA_W), .SYNC_STG(2), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .cs       (cs),
        .sclk     (sclk),
        .sdi      (sdi),
        .ldac     (ldac),
        .dout     (dout),
        .dout_vld (dout_vld),
        .frm_err  (frm_err),
        .busy     (busy),
        .frm_cnt  (frm_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (dout_vld) vld_cnt++;
            if (frm_err)  err_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sclk_bit(input logic b);
        sdi  = b;
        sclk = 1'b0;
        wait_clk(2);
        sclk = 1'b1;
        wait_clk(2);
    endtask

    task automatic mark();
        base_vld = vld_cnt;
        base_err = err_cnt;
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] data, input int nedges, input int gap);
        cs = 1'b0;
        wait_clk(3);
        for (int i = 0; i < nedges; i++) begin
            sclk_bit((i < DATA_W) ? data[DATA_W-1-i] : 1'b0);
        end
        sclk = 1'b0;
        wait_clk(2);
        cs = 1'b1;
        wait_clk(gap);
    endtask

    task automatic ldac_pulse();
        ldac = 1'b0;
        wait_clk(4);
        ldac = 1'b1;
        wait_clk(6);
    endtask

    initial begin
        // 1: reset and idle
        wait_clk(10);
        rst = 1'b0;
        wait_clk(10);
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_vld", 32'(dout_vld), 32'h0);
        check("rst_err", 32'(frm_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_cnt", 32'(frm_cnt), 32'h0);

        // 2: single good frame, busy seen mid-frame
        mark();
        cs = 1'b0;
        wait_clk(3);
        for (int i = 0; i < DATA_W; i++) sclk_bit(1'(16'hC5F2 >> (DATA_W-1-i)));
        sclk = 1'b0;
        wait_clk(2);
        check("t2_busy_mid", 32'(busy), 32'h1);
        cs = 1'b1;
        wait_clk(8);
        check("t2_busy_end", 32'(busy), 32'h0);
        check("t2_cnt", 32'(frm_cnt), 32'h1);
        check("t2_err", 32'(err_cnt - base_err), 32'h0);
`ifdef LDAC_LATCH_EN
        check("t2_dout_pre", 32'(dout), 32'h0);
        check("t2_vld_pre", 32'(vld_cnt - base_vld), 32'h0);
        ldac_pulse();
        wait_clk(10);
`endif
        check("t2_dout", 32'(dout), 32'hC5F2);
        check("t2_vld", 32'(vld_cnt - base_vld), 32'h1);

        // 3: underrun and overrun
        mark();
        send_frame(16'h1357, 15, 8);
        check("t3_under_err", 32'(err_cnt - base_err), 32'h1);
        check("t3_under_cnt", 32'(frm_cnt), 32'h1);
        check("t3_under_dout", 32'(dout), 32'hC5F2);
        send_frame(16'h2468, 17, 8);
        check("t3_over_err", 32'(err_cnt - base_err), 32'h2);
        check("t3_over_cnt", 32'(frm_cnt), 32'h1);
        check("t3_over_dout", 32'(dout), 32'hC5F2);
        check("t3_vld", 32'(vld_cnt - base_vld), 32'h0);

        // 4: reset in the middle of a frame, then a clean frame
        cs = 1'b0;
        wait_clk(3);
        for (int i = 0; i < 8; i++) sclk_bit(1'b1);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        mark();
        for (int i = 0; i < 8; i++) sclk_bit(1'b0);
        sclk = 1'b0;
        wait_clk(2);
        check("t4_busy", 32'(busy), 32'h0);
        cs = 1'b1;
        wait_clk(8);
        check("t4_err", 32'(err_cnt - base_err), 32'h0);
        check("t4_vld", 32'(vld_cnt - base_vld), 32'h0);
        check("t4_cnt0", 32'(frm_cnt), 32'h0);
        send_frame(16'h0001, 16, 8);
`ifdef LDAC_LATCH_EN
        ldac_pulse();
`endif
        check("t4_dout", 32'(dout), 32'h0001);
        check("t4_cnt1", 32'(frm_cnt), 32'h1);

        // 5: back-to-back frames from a fresh reset, then counter wrap
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(10);
        mark();
        send_frame(16'hFFFF, 16, 3);
        send_frame(16'h0000, 16, 8);
        check("t5_cnt", 32'(frm_cnt), 32'h2);
        check("t5_err", 32'(err_cnt - base_err), 32'h0);
`ifdef LDAC_LATCH_EN
        ldac_pulse();
        check("t5_vld", 32'(vld_cnt - base_vld), 32'h1);
`else
        check("t5_vld", 32'(vld_cnt - base_vld), 32'h2);
`endif
        check("t5_dout", 32'(dout), 32'h0000);
        for (int i = 0; i < 13; i++) send_frame(16'(i + 16'h0100), 16, 3);
        wait_clk(5);
        check("t5_cnt_max", 32'(frm_cnt), 32'hF);
        send_frame(16'h0BAD, 16, 8);
        check("t5_cnt_wrap", 32'(frm_cnt), 32'h0);

        // 6: ldac strobe in the middle of a frame
        send_frame(16'h1234, 16, 8);
`ifdef LDAC_LATCH_EN
        ldac_pulse();
`endif
        check("t6_dout_prev", 32'(dout), 32'h1234);
        cs = 1'b0;
        wait_clk(3);
        for (int i = 0; i < 8; i++) sclk_bit(1'(16'hA55A >> (DATA_W-1-i)));
        ldac_pulse();
        for (int i = 8; i < DATA_W; i++) sclk_bit(1'(16'hA55A >> (DATA_W-1-i)));
        sclk = 1'b0;
        wait_clk(2);
        cs = 1'b1;
        wait_clk(8);
`ifdef LDAC_LATCH_EN
        check("t6_dout_mid", 32'(dout), 32'h1234);
        ldac_pulse();
`endif
        check("t6_dout_new", 32'(dout), 32'hA55A);
        check("t6_cnt", 32'(frm_cnt), 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
